// File: rtl/taken_pred_ras.sv
// Fetch-stage next-PC predictor: jumps predicted taken, calls push return addresses,
// returns pop them. The return-address stack is built only when RAS_PRED_EN is defined.
module taken_pred_ras #(
  parameter int ADDR_W    = 48,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         F_stall_i,
  input  logic [3:0]                   f_icode_i,
  input  logic [ADDR_W-1:0]            f_valC_i,
  input  logic [ADDR_W-1:0]            f_valP_i,
  input  logic                         redirect_i,
  input  logic [ADDR_W-1:0]            redirect_pc_i,
  output logic [ADDR_W-1:0]            F_predPC_o,
  output logic                         F_rasHit_o,
  output logic [$clog2(RAS_DEPTH):0]   F_rasCount_o
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam int PW = $clog2(RAS_DEPTH);

  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  logic [ADDR_W-1:0] pred_pc_q, pred_pc_d;
  logic              ras_hit_q, ras_hit_d;

`ifdef RAS_PRED_EN
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     top_q, top_d;
  logic [PW-1:0]     push_idx;
  logic              push_en;
  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];

  assign push_idx = top_q + PW'(1);

  // Redirect outranks stall so recovery is never blocked by a fetch bubble.
  always_comb begin
    pred_pc_d = pred_pc_q;
    ras_hit_d = ras_hit_q;
    count_d   = count_q;
    top_d     = top_q;
    push_en   = 1'b0;
    if (redirect_i) begin
      pred_pc_d = redirect_pc_i;
      ras_hit_d = 1'b0;
      count_d   = '0;
      top_d     = '0;
    end else if (!F_stall_i) begin
      ras_hit_d = 1'b0;
      pred_pc_d = f_valP_i;
      case (f_icode_i)
        IJXX: pred_pc_d = f_valC_i;
        ICALL: begin
          pred_pc_d = f_valC_i;
          push_en   = 1'b1;
          top_d     = push_idx;
          // Full stack wraps and silently overwrites the oldest entry.
          count_d   = (count_q == FULL) ? count_q : count_q + CW'(1);
        end
        IRET: begin
          if (count_q != '0) begin
            pred_pc_d = stack_q[top_q];
            ras_hit_d = 1'b1;
            top_d     = top_q - PW'(1);
            count_d   = count_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_pc_q <= '0;
      ras_hit_q <= 1'b0;
      count_q   <= '0;
      top_q     <= '0;
    end else begin
      pred_pc_q <= pred_pc_d;
      ras_hit_q <= ras_hit_d;
      count_q   <= count_d;
      top_q     <= top_d;
    end
  end

  // Entries are never reset; the count alone says which ones are meaningful.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[push_idx] <= f_valP_i;
    end
  end

  assign F_rasCount_o = count_q;
`else
  always_comb begin
    pred_pc_d = pred_pc_q;
    ras_hit_d = 1'b0;
    if (redirect_i) begin
      pred_pc_d = redirect_pc_i;
    end else if (!F_stall_i) begin
      if (f_icode_i == IJXX || f_icode_i == ICALL) begin
        pred_pc_d = f_valC_i;
      end else begin
        pred_pc_d = f_valP_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_pc_q <= '0;
      ras_hit_q <= 1'b0;
    end else begin
      pred_pc_q <= pred_pc_d;
      ras_hit_q <= ras_hit_d;
    end
  end

  assign F_rasCount_o = '0;
`endif

  assign F_predPC_o = pred_pc_q;
  assign F_rasHit_o = ras_hit_q;

endmodule

// File: tb/tb_taken_pred_ras.sv
// Directed bench for taken_pred_ras; expectations follow the RAS_PRED_EN build setting.
module tb_taken_pred_ras;

  localparam int ADDR_W    = 48;
  localparam int RAS_DEPTH = 8;
  localparam int CW        = $clog2(RAS_DEPTH) + 1;

`ifdef RAS_PRED_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  logic              clk;
  logic              rst;
  logic              F_stall_i;
  logic [3:0]        f_icode_i;
  logic [ADDR_W-1:0] f_valC_i;
  logic [ADDR_W-1:0] f_valP_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic [ADDR_W-1:0] F_predPC_o;
  logic              F_rasHit_o;
  logic [CW-1:0]     F_rasCount_o;

  int n_cmp = 0;
  int n_err = 0;

  taken_pred_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .F_stall_i     (F_stall_i),
    .f_icode_i     (f_icode_i),
    .f_valC_i      (f_valC_i),
    .f_valP_i      (f_valP_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .F_predPC_o    (F_predPC_o),
    .F_rasHit_o    (F_rasHit_o),
    .F_rasCount_o  (F_rasCount_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [63:0] pc, input logic hit,
                           input logic [63:0] cnt);
    check({tag, "_pc"}, 64'(F_predPC_o), pc);
    check({tag, "_hit"}, 64'(F_rasHit_o), 64'(hit));
    check({tag, "_cnt"}, 64'(F_rasCount_o), RAS_ON ? cnt : 64'd0);
  endtask

  // Drive one fetch cycle at the falling edge, sample just after the rising edge.
  task automatic step(input logic [3:0] icode, input logic [63:0] valc, input logic [63:0] valp,
                      input logic stall, input logic redir, input logic [63:0] rpc);
    @(negedge clk);
    f_icode_i     = icode;
    f_valC_i      = valc[ADDR_W-1:0];
    f_valP_i      = valp[ADDR_W-1:0];
    F_stall_i     = stall;
    redirect_i    = redir;
    redirect_pc_i = rpc[ADDR_W-1:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    F_stall_i = 1'b0;
    f_icode_i = INOP;
    f_valC_i = '0;
    f_valP_i = '0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 64'h0, 1'b0, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Jump predicted taken.
    step(IJXX, 64'h100, 64'h00A, 1'b0, 1'b0, 64'h0);
    check_all("ijxx", 64'h100, 1'b0, 64'd0);

    // Call then matching return.
    step(ICALL, 64'h200, 64'h015, 1'b0, 1'b0, 64'h0);
    check_all("call1", 64'h200, 1'b0, 64'd1);
    step(IRET, 64'h0, 64'h201, 1'b0, 1'b0, 64'h0);
    check_all("ret1", RAS_ON ? 64'h015 : 64'h201, RAS_ON, 64'd0);

    step(INOP, 64'h77, 64'h050, 1'b0, 1'b0, 64'h0);
    check_all("nop", 64'h050, 1'b0, 64'd0);

    // Nine calls into an eight-deep stack, then nine returns.
    for (int i = 0; i < 9; i++) begin
      step(ICALL, 64'h300 + 64'(i), 64'h10 + 64'(i), 1'b0, 1'b0, 64'h0);
      check_all("ovf_call", 64'h300 + 64'(i), 1'b0, (i < 8) ? 64'(i + 1) : 64'd8);
    end
    for (int i = 0; i < 9; i++) begin
      step(IRET, 64'h0, 64'h500 + 64'(i), 1'b0, 1'b0, 64'h0);
      if (i < 8)
        check_all("ovf_ret", RAS_ON ? 64'h18 - 64'(i) : 64'h500 + 64'(i), RAS_ON, 64'(7 - i));
      else
        check_all("ovf_ret_empty", 64'h500 + 64'(i), 1'b0, 64'd0);
    end

    // Redirect beats stall and suppresses the push.
    step(ICALL, 64'h999, 64'h030, 1'b1, 1'b1, 64'h400);
    check_all("redir", 64'h400, 1'b0, 64'd0);
    step(IRET, 64'h0, 64'h600, 1'b0, 1'b0, 64'h0);
    check_all("redir_ret", 64'h600, 1'b0, 64'd0);

    // Stall holds prediction and stack.
    step(ICALL, 64'h700, 64'h041, 1'b0, 1'b0, 64'h0);
    step(ICALL, 64'h710, 64'h042, 1'b0, 1'b0, 64'h0);
    check_all("stall_pre", 64'h710, 1'b0, 64'd2);
    for (int i = 0; i < 3; i++) begin
      step(IRET, 64'h0, 64'h800, 1'b1, 1'b0, 64'h0);
      check_all("stall_hold", 64'h710, 1'b0, 64'd2);
    end
    step(IRET, 64'h0, 64'h800, 1'b0, 1'b0, 64'h0);
    check_all("stall_rel", RAS_ON ? 64'h042 : 64'h800, RAS_ON, 64'd1);

    // Mid-cycle asynchronous reset after several calls.
    step(INOP, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(ICALL, 64'hA00 + 64'(i), 64'h61 + 64'(i), 1'b0, 1'b0, 64'h0);
    end
    step(IRET, 64'h0, 64'hB00, 1'b0, 1'b0, 64'h0);
    check_all("pre_rst", RAS_ON ? 64'h063 : 64'hB00, RAS_ON, 64'd2);
    #1;
    rst = 1'b1;
    #1;
    check_all("async_rst", 64'h0, 1'b0, 64'd0);
    rst = 1'b0;
    step(IRET, 64'h0, 64'h900, 1'b0, 1'b0, 64'h0);
    check_all("post_rst_ret", 64'h900, 1'b0, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/taken_pred_ras.md
TAKEN_PRED_RAS -- requirements
Module: taken_pred_ras

Interface
REQ-001 SHALL have parameter ADDR_W, default 48, width of every PC/address bus.
REQ-002 SHALL have parameter RAS_DEPTH, default 8, return-address-stack entries; power of two, >=2.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port F_stall_i  input  1  hold predicted PC and stack when asserted.
REQ-006 SHALL have port f_icode_i  input  4  fetched instruction code, per shared defines (IJXX, ICALL, IRET).
REQ-007 SHALL have port f_valC_i  input  ADDR_W  fetched constant word (jump/call target).
REQ-008 SHALL have port f_valP_i  input  ADDR_W  fall-through PC.
REQ-009 SHALL have port redirect_i  input  1  misprediction recovery request from a later stage.
REQ-010 SHALL have port redirect_pc_i  input  ADDR_W  corrected PC for redirect.
REQ-011 SHALL have port F_predPC_o  output  ADDR_W  registered predicted next PC.
REQ-012 SHALL have port F_rasHit_o  output  1  registered; 1 when current F_predPC_o came from the stack.
REQ-013 SHALL have port F_rasCount_o  output  clog2(RAS_DEPTH)+1  registered valid-entry count.

Function
REQ-014 Update priority per edge SHALL be: rst > redirect_i > F_stall_i > normal prediction.
REQ-015 redirect_i=1 SHALL load F_predPC_o<=redirect_pc_i, clear stack (count 0, top pointer 0), F_rasHit_o<=0, regardless of F_stall_i.
REQ-016 F_stall_i=1 without redirect SHALL hold F_predPC_o, F_rasHit_o, stack contents and count unchanged.
REQ-017 Normal, icode IJXX SHALL load F_predPC_o<=f_valC_i (predict taken), stack unchanged, F_rasHit_o<=0.
REQ-018 Normal, icode ICALL SHALL load F_predPC_o<=f_valC_i and push f_valP_i; F_rasHit_o<=0.
REQ-019 Push SHALL write at top pointer+1 (mod RAS_DEPTH), advance pointer; count increments, saturating at RAS_DEPTH.
REQ-020 Push when full SHALL overwrite oldest entry (circular wrap); count stays RAS_DEPTH.
REQ-021 Normal, icode IRET, count>0 SHALL load F_predPC_o<=stack top, pop (pointer-1 mod RAS_DEPTH, count-1), F_rasHit_o<=1.
REQ-022 Normal, icode IRET, count=0 SHALL load F_predPC_o<=f_valP_i, no pointer change, F_rasHit_o<=0.
REQ-023 Any other icode SHALL load F_predPC_o<=f_valP_i, stack unchanged, F_rasHit_o<=0.
REQ-024 Latency SHALL be one cycle: prediction for inputs at edge N visible after edge N.
REQ-025 Address arithmetic SHALL not occur; pointer arithmetic SHALL wrap modulo RAS_DEPTH.
REQ-026 Stack storage SHALL be flops; contents not reset, validity governed by count only.

Reset
REQ-027 rst=1 SHALL asynchronously force F_predPC_o=0, F_rasHit_o=0, F_rasCount_o=0, top pointer=0.
REQ-028 rst asserted mid-sequence SHALL discard all pending stack state; first post-reset IRET predicts f_valP_i.

Configuration
REQ-029 Macro RAS_PRED_EN SHALL select stack inclusion.
REQ-030 With RAS_PRED_EN defined, behaviour SHALL be REQ-018..REQ-022 as written.
REQ-031 Without RAS_PRED_EN, no stack storage SHALL be built; ICALL predicts f_valC_i, IRET predicts f_valP_i, F_rasHit_o and F_rasCount_o tied 0.

Verification
REQ-032 Reset then IJXX valC=0x100, valP=0x00A -> F_predPC_o=0x100, F_rasHit_o=0.
REQ-033 ICALL valC=0x200 valP=0x015, then IRET valP=0x201 -> predPC 0x200, then 0x015 with F_rasHit_o=1, count 1->0.
REQ-034 RAS_DEPTH=8: 9 ICALLs valP=0x10..0x18, then 9 IRETs -> returns 0x18..0x11 (hit=1), 9th IRET predicts its valP, hit=0; count saturates at 8.
REQ-035 ICALL valP=0x30 with F_stall_i=1 and redirect_i=1, redirect_pc_i=0x400 -> predPC 0x400, count 0, no push.
REQ-036 Two ICALLs, then F_stall_i=1 for 3 cycles with IRET presented -> predPC and count unchanged; release -> IRET pops second return.
REQ-037 rst pulsed between clock edges after 3 ICALLs -> outputs zero immediately; next IRET predicts valP, hit=0.
